// File: rtl/sys_defs.sv
// Shared front-end types: instruction/address words, the instruction-buffer entry and the NOP encoding.
`ifndef NOP
`define NOP 32'h0000_0013
`endif

package sys_defs;
    localparam int INST_BUFFER_DEPTH = 8;

    typedef logic [31:0] INST;
    typedef logic [31:0] ADDR;

    typedef struct packed {
        INST inst;
        ADDR pc;
    } IB_ENTRY;
endpackage

// File: rtl/ib_ptr.sv
// Wrapping pointer register: increments modulo 2**W, synchronous clear (flush), async active-low reset.
module ib_ptr #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   ptr <= '0;
        else if (clear) ptr <= '0;
        else if (inc)   ptr <= ptr + W'(1);
    end
endmodule

// File: rtl/inst_buffer.sv
// Circular fetch->decode instruction queue with flush.
// INST_BUFFER_BYPASS_EN: an empty buffer forwards the fetch slot straight to the decoder.
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module inst_buffer
    import sys_defs::*;
#(
    parameter int DEPTH = INST_BUFFER_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  logic [31:0]                enq_inst,
    input  logic [31:0]                enq_pc,
    output logic                       enq_ready,
    output logic                       deq_valid,
    output logic [31:0]                deq_inst,
    output logic [31:0]                deq_pc,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    IB_ENTRY         mem [DEPTH];
    IB_ENTRY         head_ent;
    logic [PW-1:0]   head, tail;
    logic            full, empty, enq_fire, wr_en, rd_en;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign enq_ready = !full;
    assign enq_fire  = enq_valid && enq_ready && !flush;

`ifdef INST_BUFFER_BYPASS_EN
    logic bypass;
    assign bypass    = empty && enq_valid && !flush;
    assign deq_valid = (!empty && !flush) || bypass;
    // A bypassed instruction taken by decode the same cycle never touches storage.
    assign wr_en     = enq_fire && !(bypass && deq_ready);
    assign rd_en     = deq_valid && deq_ready && !bypass;
    assign head_ent  = bypass ? '{inst: enq_inst, pc: enq_pc} : mem[head];
`else
    assign deq_valid = !empty && !flush;
    assign wr_en     = enq_fire;
    assign rd_en     = deq_valid && deq_ready;
    assign head_ent  = mem[head];
`endif

    assign deq_inst = deq_valid ? head_ent.inst : `NOP;
    assign deq_pc   = deq_valid ? head_ent.pc   : '0;

    ib_ptr #(.W(PW)) u_head (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (flush),
        .inc     (rd_en),
        .ptr     (head)
    );

    ib_ptr #(.W(PW)) u_tail (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (flush),
        .inc     (wr_en),
        .ptr     (tail)
    );

    // Storage is never cleared; occupancy alone decides what is live.
    always_ff @(posedge clock) begin
        if (wr_en) mem[tail] <= '{inst: enq_inst, pc: enq_pc};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   count <= '0;
        else if (flush) count <= '0;
        else begin
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
